// File: rtl/res_station_param_pkg.sv
// res_station_param_pkg
// Shared types and default parameters for the reservation station.
//   op_t                 : 4-bit functional-unit operation code
//   RS_*_DEFAULT         : default geometry used by the station and its interface
package res_station_param_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLL    = 4'd5,
        OP_SRL    = 4'd6,
        OP_SRA    = 4'd7,
        OP_SLT    = 4'd8,
        OP_SLTU   = 4'd9,
        OP_LUI    = 4'd10,
        OP_AUIPC  = 4'd11,
        OP_BRANCH = 4'd12,
        OP_JAL    = 4'd13,
        OP_JALR   = 4'd14,
        OP_MEM    = 4'd15
    } op_t;

    localparam int RS_DEPTH_DEFAULT   = 4;
    localparam int RS_TAG_W_DEFAULT   = 3;
    localparam int RS_NUM_CDB_DEFAULT = 2;
    localparam int RS_XLEN_DEFAULT    = 32;

endpackage

// File: rtl/res_station_param_if.sv
// res_station_param_if
// Dispatch, CDB snoop and issue buses of the reservation station.
//   alloc_*  : dispatch stage -> station (alloc_valid/alloc_ready handshake)
//   cdb_*    : NUM_CDB broadcast channels, channel i in slice i (no handshake)
//   issue_*  : station -> functional unit (issue_valid/issue_ready handshake)
// Modports: master = dispatch/CDB/FU side, slave = reservation station.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. Neither side's valid depends combinationally on its ready.
// issue_* payload is held while issue_valid & !issue_ready, except that it
// switches to an older entry if one becomes ready (oldest is always shown).
interface res_station_param_if #(
    parameter int TAG_W   = res_station_param_pkg::RS_TAG_W_DEFAULT,
    parameter int NUM_CDB = res_station_param_pkg::RS_NUM_CDB_DEFAULT,
    parameter int XLEN    = res_station_param_pkg::RS_XLEN_DEFAULT
);
    logic                      alloc_valid;
    logic                      alloc_ready;
    res_station_param_pkg::op_t alloc_op;
    logic [2:0]                alloc_funct3;
    logic                      alloc_funct7;
    logic                      alloc_src1_valid;
    logic                      alloc_src2_valid;
    logic [TAG_W-1:0]          alloc_src1_tag;
    logic [TAG_W-1:0]          alloc_src2_tag;
    logic [XLEN-1:0]           alloc_src1_data;
    logic [XLEN-1:0]           alloc_src2_data;
    logic [TAG_W-1:0]          alloc_rd_tag;
    logic [XLEN-1:0]           alloc_pc;

    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag;
    logic [NUM_CDB*XLEN-1:0]   cdb_data;

    logic                      issue_valid;
    logic                      issue_ready;
    res_station_param_pkg::op_t issue_op;
    logic [2:0]                issue_funct3;
    logic                      issue_funct7;
    logic [XLEN-1:0]           issue_src1_data;
    logic [XLEN-1:0]           issue_src2_data;
    logic [XLEN-1:0]           issue_pc;
    logic [TAG_W-1:0]          issue_tag;

    modport master (
        output alloc_valid, alloc_op, alloc_funct3, alloc_funct7,
               alloc_src1_valid, alloc_src2_valid, alloc_src1_tag, alloc_src2_tag,
               alloc_src1_data, alloc_src2_data, alloc_rd_tag, alloc_pc,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        input  alloc_ready, issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1_data, issue_src2_data, issue_pc, issue_tag
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_funct3, alloc_funct7,
               alloc_src1_valid, alloc_src2_valid, alloc_src1_tag, alloc_src2_tag,
               alloc_src1_data, alloc_src2_data, alloc_rd_tag, alloc_pc,
               cdb_valid, cdb_tag, cdb_data, issue_ready,
        output alloc_ready, issue_valid, issue_op, issue_funct3, issue_funct7,
               issue_src1_data, issue_src2_data, issue_pc, issue_tag
    );
endinterface

// File: rtl/res_station_param_age_matrix.sv
// res_station_param_age_matrix
// DEPTH x DEPTH age matrix: older[i][j] = 1 means entry i was allocated
// before entry j. Picks the oldest entry out of a ready vector.
//   clk, rst, flush : clock, sync active-high reset, clear-all
//   busy            : occupied entries before this edge
//   alloc_onehot    : entry written this edge (0 if none)
//   issue_onehot    : entry freed this edge (0 if none)
//   ready           : candidates for selection
//   oldest          : one-hot oldest ready entry (0 if none ready)
module res_station_param_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] alloc_onehot,
    input  logic [DEPTH-1:0] issue_onehot,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] oldest
);
    logic [DEPTH-1:0] older [DEPTH];
    logic [DEPTH-1:0] col   [DEPTH];

    // A new entry is younger than every surviving entry and older than none.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_onehot[j])
                        older[i][j] <= busy[i] & ~issue_onehot[i];
                    else if (alloc_onehot[i] || issue_onehot[i] || issue_onehot[j])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    // col[i][j] = entry j is older than entry i
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            col[i] = '0;
            for (int j = 0; j < DEPTH; j++) col[i][j] = older[j][i];
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++)
            oldest[i] = ready[i] & ~|(col[i] & ready);
    end
endmodule

// File: rtl/res_station_param.sv
// res_station_param
// Parametrised Tomasulo reservation station. Holds up to DEPTH dispatched
// instructions, wakes waiting operands from NUM_CDB broadcast channels and
// issues the oldest ready entry to one functional unit.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears all entries)
//   flush : discard all entries at the edge; issue_valid forced 0 this cycle
//   rs    : res_station_param_if.slave (alloc_*, cdb_*, issue_*)
//   count : occupied entries
// Build option RS_WAKE_ISSUE_EN: an entry completed by a CDB broadcast can
// issue in the same cycle, operand data muxed straight from cdb_data.
module res_station_param
    import res_station_param_pkg::*;
#(
    parameter int  DEPTH   = RS_DEPTH_DEFAULT,
    parameter int  TAG_W   = RS_TAG_W_DEFAULT,
    parameter int  NUM_CDB = RS_NUM_CDB_DEFAULT,
    parameter int  XLEN    = RS_XLEN_DEFAULT,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    res_station_param_if.slave rs,
    output logic [CNT_W-1:0] count
);
    typedef struct packed {
        logic             busy;
        op_t              op;
        logic [2:0]       funct3;
        logic             funct7;
        logic             src1_valid;
        logic [TAG_W-1:0] src1_tag;
        logic [XLEN-1:0]  src1_data;
        logic             src2_valid;
        logic [TAG_W-1:0] src2_tag;
        logic [XLEN-1:0]  src2_data;
        logic [TAG_W-1:0] rd_tag;
        logic [XLEN-1:0]  pc;
    } entry_t;

    entry_t           ent [DEPTH];
    entry_t           new_ent;
    logic [DEPTH-1:0] busy, free_onehot, ready, sel, alloc_onehot, issue_onehot;
    logic [DEPTH-1:0] hit1, hit2;
    logic [XLEN-1:0]  wdata1 [DEPTH];
    logic [XLEN-1:0]  wdata2 [DEPTH];
    logic [XLEN-1:0]  eff1   [DEPTH];
    logic [XLEN-1:0]  eff2   [DEPTH];
    logic             a_hit1, a_hit2;
    logic [XLEN-1:0]  a_data1, a_data2;
    logic             alloc_ready, issue_valid, alloc_fire, issue_fire;

    // CDB tag match for stored and incoming operands. Channels are scanned
    // from high to low so the lowest matching channel wins.
    always_comb begin
        hit1 = '0;
        hit2 = '0;
        a_hit1 = 1'b0;
        a_hit2 = 1'b0;
        a_data1 = '0;
        a_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wdata1[i] = '0;
            wdata2[i] = '0;
        end
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (rs.cdb_valid[c]) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (rs.cdb_tag[c*TAG_W +: TAG_W] == ent[i].src1_tag) begin
                        hit1[i] = 1'b1;
                        wdata1[i] = rs.cdb_data[c*XLEN +: XLEN];
                    end
                    if (rs.cdb_tag[c*TAG_W +: TAG_W] == ent[i].src2_tag) begin
                        hit2[i] = 1'b1;
                        wdata2[i] = rs.cdb_data[c*XLEN +: XLEN];
                    end
                end
                if (rs.cdb_tag[c*TAG_W +: TAG_W] == rs.alloc_src1_tag) begin
                    a_hit1 = 1'b1;
                    a_data1 = rs.cdb_data[c*XLEN +: XLEN];
                end
                if (rs.cdb_tag[c*TAG_W +: TAG_W] == rs.alloc_src2_tag) begin
                    a_hit2 = 1'b1;
                    a_data2 = rs.cdb_data[c*XLEN +: XLEN];
                end
            end
        end
    end

    // Readiness and operand values presented to the issue mux.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            busy[i] = ent[i].busy;
`ifdef RS_WAKE_ISSUE_EN
            ready[i] = ent[i].busy & (ent[i].src1_valid | hit1[i]) & (ent[i].src2_valid | hit2[i]);
            eff1[i]  = ent[i].src1_valid ? ent[i].src1_data : wdata1[i];
            eff2[i]  = ent[i].src2_valid ? ent[i].src2_data : wdata2[i];
`else
            ready[i] = ent[i].busy & ent[i].src1_valid & ent[i].src2_valid;
            eff1[i]  = ent[i].src1_data;
            eff2[i]  = ent[i].src2_data;
`endif
        end
    end

    // Lowest-index free entry, from registered busy bits only.
    always_comb begin
        free_onehot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_onehot = '0;
                free_onehot[i] = 1'b1;
            end
        end
    end

    assign alloc_ready  = (count < CNT_W'(DEPTH));
    assign issue_valid  = (|ready) & ~flush;
    assign alloc_fire   = rs.alloc_valid & alloc_ready & ~flush;
    assign issue_fire   = issue_valid & rs.issue_ready;
    assign alloc_onehot = free_onehot & {DEPTH{alloc_fire}};
    assign issue_onehot = sel & {DEPTH{issue_fire}};
    assign rs.alloc_ready = alloc_ready;
    assign rs.issue_valid = issue_valid;

    res_station_param_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .busy         (busy),
        .alloc_onehot (alloc_onehot),
        .issue_onehot (issue_onehot),
        .ready        (ready),
        .oldest       (sel)
    );

    // Issue payload: zero unless an entry is actually being presented.
    always_comb begin
        rs.issue_op        = OP_ADD;
        rs.issue_funct3    = '0;
        rs.issue_funct7    = 1'b0;
        rs.issue_src1_data = '0;
        rs.issue_src2_data = '0;
        rs.issue_pc        = '0;
        rs.issue_tag       = '0;
        if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sel[i]) begin
                    rs.issue_op        = ent[i].op;
                    rs.issue_funct3    = ent[i].funct3;
                    rs.issue_funct7    = ent[i].funct7;
                    rs.issue_src1_data = eff1[i];
                    rs.issue_src2_data = eff2[i];
                    rs.issue_pc        = ent[i].pc;
                    rs.issue_tag       = ent[i].rd_tag;
                end
            end
        end
    end

    // Incoming entry, with operands captured from a same-cycle broadcast.
    always_comb begin
        new_ent.busy       = 1'b1;
        new_ent.op         = rs.alloc_op;
        new_ent.funct3     = rs.alloc_funct3;
        new_ent.funct7     = rs.alloc_funct7;
        new_ent.src1_valid = rs.alloc_src1_valid | a_hit1;
        new_ent.src1_tag   = rs.alloc_src1_tag;
        new_ent.src1_data  = (!rs.alloc_src1_valid && a_hit1) ? a_data1 : rs.alloc_src1_data;
        new_ent.src2_valid = rs.alloc_src2_valid | a_hit2;
        new_ent.src2_tag   = rs.alloc_src2_tag;
        new_ent.src2_data  = (!rs.alloc_src2_valid && a_hit2) ? a_data2 : rs.alloc_src2_data;
        new_ent.rd_tag     = rs.alloc_rd_tag;
        new_ent.pc         = rs.alloc_pc;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].busy <= 1'b0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_onehot[i]) begin
                    ent[i].busy <= 1'b0;
                end else if (alloc_onehot[i]) begin
                    ent[i] <= new_ent;
                end else if (ent[i].busy) begin
                    if (!ent[i].src1_valid && hit1[i]) begin
                        ent[i].src1_valid <= 1'b1;
                        ent[i].src1_data  <= wdata1[i];
                    end
                    if (!ent[i].src2_valid && hit2[i]) begin
                        ent[i].src2_valid <= 1'b1;
                        ent[i].src2_data  <= wdata2[i];
                    end
                end
            end
            count <= count + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
        end
    end
endmodule

// File: tb/tb_res_station_param.sv
// tb_res_station_param
// Self-checking bench for res_station_param. Expected issue records
// {rd_tag, src1_data, src2_data} are queued when stimulus is driven and
// compared by a monitor whenever an issue handshake completes.
// Honours RS_WAKE_ISSUE_EN for wake-to-issue timing expectations.
module tb_res_station_param;
    import res_station_param_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 3;
    localparam int NUM_CDB = 2;
    localparam int XLEN    = 32;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int W       = TAG_W + 2 * XLEN;
`ifdef RS_WAKE_ISSUE_EN
    localparam logic WAKE = 1'b1;
`else
    localparam logic WAKE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [CNT_W-1:0] count;
    int               checks   = 0;
    int               failures = 0;
    logic [W-1:0]     exp_q[$];

    res_station_param_if #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) rs_if ();

    res_station_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .rs    (rs_if.slave),
        .count (count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got, e;
        if (!rst && rs_if.issue_valid && rs_if.issue_ready) begin
            got = {rs_if.issue_tag, rs_if.issue_src1_data, rs_if.issue_src2_data};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got %h, queue empty", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL issue_record: got %h expected %h", got, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        rs_if.alloc_valid      = 1'b0;
        rs_if.alloc_op         = OP_ADD;
        rs_if.alloc_funct3     = '0;
        rs_if.alloc_funct7     = 1'b0;
        rs_if.alloc_src1_valid = 1'b0;
        rs_if.alloc_src2_valid = 1'b0;
        rs_if.alloc_src1_tag   = '0;
        rs_if.alloc_src2_tag   = '0;
        rs_if.alloc_src1_data  = '0;
        rs_if.alloc_src2_data  = '0;
        rs_if.alloc_rd_tag     = '0;
        rs_if.alloc_pc         = '0;
        rs_if.cdb_valid        = '0;
        rs_if.cdb_tag          = '0;
        rs_if.cdb_data         = '0;
        flush                  = 1'b0;
    endtask

    task automatic set_alloc(input logic [TAG_W-1:0] rd,
                             input logic v1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] d1,
                             input logic v2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] d2);
        rs_if.alloc_valid      = 1'b1;
        rs_if.alloc_op         = OP_ADD;
        rs_if.alloc_funct3     = 3'd0;
        rs_if.alloc_funct7     = 1'b0;
        rs_if.alloc_src1_valid = v1;
        rs_if.alloc_src1_tag   = t1;
        rs_if.alloc_src1_data  = d1;
        rs_if.alloc_src2_valid = v2;
        rs_if.alloc_src2_tag   = t2;
        rs_if.alloc_src2_data  = d2;
        rs_if.alloc_rd_tag     = rd;
        rs_if.alloc_pc         = 32'h1000 + 32'(rd) * 4;
    endtask

    task automatic wait_drain(input string name);
        rs_if.issue_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d records left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        rs_if.issue_ready = 1'b0;
        sample();
        checks++;
        if (count !== 0) begin
            failures++;
            $display("FAIL %s_count_after_drain: got %0d expected 0", name, count);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        rs_if.issue_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sample();
        checks++;
        if (rs_if.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready: got %b expected 1", rs_if.alloc_ready); end
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid: got %b expected 0", rs_if.issue_valid); end
        checks++;
        if (count !== 0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if ({rs_if.issue_tag, rs_if.issue_src1_data, rs_if.issue_src2_data, rs_if.issue_pc} !== '0) begin
            failures++;
            $display("FAIL reset_issue_data: got tag=%h s1=%h s2=%h pc=%h expected all 0",
                     rs_if.issue_tag, rs_if.issue_src1_data, rs_if.issue_src2_data, rs_if.issue_pc);
        end
    endtask

    task automatic test_basic();
        tick();
        rs_if.issue_ready = 1'b1;
        set_alloc(3'd2, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7);
        exp_q.push_back({3'd2, 32'd5, 32'd7});
        sample();
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL basic_latency: got issue_valid %b expected 0", rs_if.issue_valid); end
        tick();
        drive_idle();
        sample();
        checks++;
        if (rs_if.issue_valid !== 1'b1) begin failures++; $display("FAIL basic_issue_valid: got %b expected 1", rs_if.issue_valid); end
        checks++;
        if (count !== 1) begin failures++; $display("FAIL basic_count_one: got %0d expected 1", count); end
        tick();
        sample();
        checks++;
        if (count !== 0) begin failures++; $display("FAIL basic_count_zero: got %0d expected 0", count); end
        rs_if.issue_ready = 1'b0;
    endtask

    task automatic test_cdb_wakeup();
        tick();
        rs_if.issue_ready = 1'b1;
        set_alloc(3'd5, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'd1);
        exp_q.push_back({3'd5, 32'hDEAD, 32'd1});
        sample();
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL wake_waiting: got issue_valid %b expected 0", rs_if.issue_valid); end
        tick();
        drive_idle();
        rs_if.cdb_valid = 2'b10;
        rs_if.cdb_tag   = {3'd3, 3'd0};
        rs_if.cdb_data  = {32'hDEAD, 32'h0};
        sample();
        checks++;
        if (rs_if.issue_valid !== WAKE) begin failures++; $display("FAIL wake_cycle_t: got issue_valid %b expected %b", rs_if.issue_valid, WAKE); end
        tick();
        drive_idle();
        sample();
        checks++;
        if (rs_if.issue_valid !== !WAKE) begin failures++; $display("FAIL wake_cycle_t1: got issue_valid %b expected %b", rs_if.issue_valid, !WAKE); end
        // both channels match: channel 0 data must be taken
        tick();
        set_alloc(3'd6, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'd2);
        exp_q.push_back({3'd6, 32'h11, 32'd2});
        tick();
        drive_idle();
        rs_if.cdb_valid = 2'b11;
        rs_if.cdb_tag   = {3'd6, 3'd6};
        rs_if.cdb_data  = {32'h22, 32'h11};
        tick();
        drive_idle();
        wait_drain("wake");
    endtask

    task automatic test_alloc_capture();
        tick();
        rs_if.issue_ready = 1'b1;
        set_alloc(3'd1, 1'b1, 3'd0, 32'h10, 1'b0, 3'd4, 32'd0);
        rs_if.cdb_valid = 2'b01;
        rs_if.cdb_tag   = {3'd0, 3'd4};
        rs_if.cdb_data  = {32'h0, 32'd9};
        exp_q.push_back({3'd1, 32'h10, 32'd9});
        sample();
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL capture_same_cycle: got issue_valid %b expected 0", rs_if.issue_valid); end
        tick();
        drive_idle();
        sample();
        checks++;
        if (rs_if.issue_src2_data !== 32'd9) begin failures++; $display("FAIL capture_src2: got %h expected 9", rs_if.issue_src2_data); end
        wait_drain("capture");
    endtask

    task automatic test_fill();
        logic [XLEN-1:0] d1, d2;
        rs_if.issue_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            d1 = $urandom();
            d2 = $urandom();
            set_alloc(TAG_W'(k + 4), 1'b1, 3'd0, d1, 1'b1, 3'd0, d2);
            exp_q.push_back({TAG_W'(k + 4), d1, d2});
        end
        tick();
        set_alloc(3'd0, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
        sample();
        checks++;
        if (count !== DEPTH) begin failures++; $display("FAIL fill_count: got %0d expected %0d", count, DEPTH); end
        checks++;
        if (rs_if.alloc_ready !== 1'b0) begin failures++; $display("FAIL fill_alloc_ready: got %b expected 0", rs_if.alloc_ready); end
        checks++;
        if (rs_if.issue_tag !== 3'd4) begin failures++; $display("FAIL fill_oldest: got tag %0d expected 4", rs_if.issue_tag); end
        tick();
        drive_idle();
        sample();
        checks++;
        if (count !== DEPTH) begin failures++; $display("FAIL fill_refused_alloc: got count %0d expected %0d", count, DEPTH); end
        checks++;
        if (rs_if.issue_tag !== 3'd4) begin failures++; $display("FAIL fill_hold: got tag %0d expected 4", rs_if.issue_tag); end
        tick();
        wait_drain("fill");
    endtask

    task automatic test_age_order();
        tick();
        rs_if.issue_ready = 1'b0;
        set_alloc(3'd1, 1'b0, 3'd7, 32'd0, 1'b1, 3'd0, 32'hA1);
        tick();
        set_alloc(3'd2, 1'b1, 3'd0, 32'hB1, 1'b1, 3'd0, 32'hB2);
        exp_q.push_back({3'd2, 32'hB1, 32'hB2});
        exp_q.push_back({3'd1, 32'hCAFE, 32'hA1});
        exp_q.push_back({3'd3, 32'hC1, 32'hC2});
        tick();
        drive_idle();
        sample();
        checks++;
        if (rs_if.issue_tag !== 3'd2) begin failures++; $display("FAIL age_ready_first: got tag %0d expected 2", rs_if.issue_tag); end
        tick();
        rs_if.issue_ready = 1'b1;
        set_alloc(3'd3, 1'b1, 3'd0, 32'hC1, 1'b1, 3'd0, 32'hC2);
        sample();
        tick();
        drive_idle();
        rs_if.issue_ready = 1'b0;
        rs_if.cdb_valid = 2'b01;
        rs_if.cdb_tag   = {3'd0, 3'd7};
        rs_if.cdb_data  = {32'h0, 32'hCAFE};
        sample();
        checks++;
        if (count !== 2) begin failures++; $display("FAIL alloc_issue_same_cycle: got count %0d expected 2", count); end
        checks++;
        if (rs_if.issue_tag !== (WAKE ? 3'd1 : 3'd3)) begin
            failures++;
            $display("FAIL age_wake_cycle: got tag %0d expected %0d", rs_if.issue_tag, WAKE ? 1 : 3);
        end
        tick();
        drive_idle();
        sample();
        checks++;
        if (rs_if.issue_tag !== 3'd1) begin failures++; $display("FAIL age_older_woken: got tag %0d expected 1", rs_if.issue_tag); end
        wait_drain("age");
    endtask

    task automatic test_flush();
        rs_if.issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            set_alloc(TAG_W'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k));
        end
        tick();
        drive_idle();
        flush = 1'b1;
        set_alloc(3'd5, 1'b1, 3'd0, 32'd1, 1'b1, 3'd0, 32'd1);
        rs_if.issue_ready = 1'b1;
        sample();
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_issue_valid: got %b expected 0", rs_if.issue_valid); end
        checks++;
        if (count !== 3) begin failures++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        tick();
        drive_idle();
        sample();
        checks++;
        if (count !== 0) begin failures++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++;
        if (rs_if.alloc_ready !== 1'b1) begin failures++; $display("FAIL flush_alloc_ready: got %b expected 1", rs_if.alloc_ready); end
        checks++;
        if (rs_if.issue_valid !== 1'b0) begin failures++; $display("FAIL flush_no_write: got issue_valid %b expected 0", rs_if.issue_valid); end
        rs_if.issue_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0]  d1, d2;
        logic [TAG_W-1:0] rd;
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick();
            drive_idle();
            rs_if.issue_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                rd = TAG_W'($urandom_range(0, 7));
                d1 = $urandom();
                d2 = $urandom();
                set_alloc(rd, 1'b1, 3'd0, d1, 1'b1, 3'd0, d2);
                if (rs_if.alloc_ready) exp_q.push_back({rd, d1, d2});
            end
        end
        tick();
        drive_idle();
        wait_drain("b2b");
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        rs_if.issue_ready = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_cdb_wakeup();
        test_alloc_capture();
        test_fill();
        test_age_order();
        test_flush();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/res_station_param.md
# res_station_param

Parametrised reservation station for the Tomasulo back end: holds up to DEPTH dispatched instructions, snoops NUM_CDB common data buses to wake waiting operands, and issues the oldest ready entry to its functional unit over a valid/ready handshake. It sits between the instruction-queue dispatch stage and one ALU/branch/address unit, and generalises the fixed 3-bit-tag, single-CDB station entry format.

## Interface
- DEPTH, 4, entry count (≥2)
- TAG_W, 3, ROB tag width
- NUM_CDB, 2, CDB broadcast channels
- XLEN, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries (mispredict)
- alloc_valid  in  1  dispatch request
- alloc_ready  out  1  station has a free entry
- alloc_op  in  4  op_t
- alloc_funct3  in  3;  alloc_funct7  in  1
- alloc_src1_valid, alloc_src2_valid  in  1 each  operand already holds data
- alloc_src1_tag, alloc_src2_tag  in  TAG_W each  producer tag when not valid
- alloc_src1_data, alloc_src2_data  in  XLEN each
- alloc_rd_tag  in  TAG_W;  alloc_pc  in  XLEN
- cdb_valid  in  NUM_CDB  per-channel broadcast valid
- cdb_tag  in  NUM_CDB*TAG_W;  cdb_data  in  NUM_CDB*XLEN  channel i in slice i
- issue_valid  out  1;  issue_ready  in  1
- issue_op, issue_funct3, issue_funct7, issue_src1_data, issue_src2_data, issue_pc  out  (widths as alloc)
- issue_tag  out  TAG_W  rd tag of issued entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry: busy, op, funct3, funct7, per-source {valid, tag, data}, rd_tag, pc, age order.
- alloc_ready = (count < DEPTH), from registered state only; no reuse of an entry freed the same cycle.
- Alloc fire (alloc_valid & alloc_ready): write lowest-index free entry; mark youngest.
- Alloc-time capture: a source arriving invalid whose tag matches a valid CDB channel that cycle is stored valid with that channel's data. Always on.
- Wakeup: every busy entry compares each invalid source tag with every valid CDB channel; on match, data and valid latch at the edge. Multiple matching channels: lowest channel index wins.
- Ready = busy & src1 valid & src2 valid. issue_valid = any ready; outputs select the oldest ready entry (earliest alloc).
- Issue fire (issue_valid & issue_ready): selected entry cleared at the edge; the remaining entries keep their relative order.
- Alloc and issue fire in the same cycle: both take effect; count unchanged.
- flush: all entries cleared at the edge and issue_valid forced 0 combinationally in that cycle; alloc and issue ignored; priority over all other events.
- rst: same as flush; all busy bits 0, count 0.

## Timing
- Reset values: alloc_ready 1, issue_valid 0, count 0, all issue_* data outputs 0 (zero when issue_valid 0).
- Alloc with both sources valid → issue_valid earliest next cycle (1-cycle latency).
- CDB broadcast at cycle t → woken entry eligible at t+1 (t with RS_WAKE_ISSUE_EN).
- issue_* are held stable while issue_valid & !issue_ready unless an older entry becomes ready (oldest always presented).
- No combinational path from issue_ready to alloc_ready.

## Configuration
- RS_WAKE_ISSUE_EN defined: an entry whose last missing operand(s) match a valid CDB channel in cycle t is ready in t; issue_src*_data is muxed from cdb_data. Adds a CDB-to-issue combinational path.
- Undefined: readiness from registered valid bits only; wake-to-issue is one cycle.

## Structure
- tomasula_types supplies op_t and gains RS_DEPTH_DEFAULT, RS_TAG_W_DEFAULT, RS_NUM_CDB_DEFAULT; the parameter-width entry struct is local to the module.
- Sub-module rs_age_matrix: DEPTH×DEPTH age bits, set on alloc, cleared on issue/flush; given a ready vector, returns a one-hot oldest selection.

## Test plan
- Reset, then alloc ADD with src1=5, src2=7 valid, rd_tag=2 → issue_valid next cycle, issue_src1_data=5, issue_src2_data=7, issue_tag=2, count 1→0 after fire.
- Alloc with src1 waiting on tag 3; CDB channel 1 broadcasts tag 3, data 0xDEAD at t → issue at t+1 (t with macro) with issue_src1_data 0xDEAD.
- Alloc with src2 tag 4 in the same cycle as CDB channel 0 broadcasting tag 4, data 9 → entry stored valid; issues next cycle with src2=9.
- Fill DEPTH=4 entries in order, all ready, issue_ready held 0 → alloc_ready 0, count 4; release → issue_tag in alloc order.
- Entries A (waiting) then B (ready): B issues first; A woken later issues after; simultaneous alloc+issue keeps count constant.
- flush with 3 busy entries and alloc_valid 1 → issue_valid 0 that cycle, count 0 and alloc_ready 1 next cycle, no entry written.
